// File: rtl/beat_pattern_gen.sv
// Beatmap note-value generator: repeating arithmetic sequence START..END by STEP,
// wrap or bounce traversal, runtime beat period, optional loop limit, valid/ready output.
module beat_pattern_gen #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned START    = 200,
    parameter int unsigned END      = 216,
    parameter int unsigned STEP     = 4,
    parameter int unsigned MODE     = 0,
    parameter int unsigned LOOPS    = 0,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic                done
);

    localparam int unsigned      PassW  = $clog2(LOOPS + 2);
    localparam logic [DATA_W:0]  StartX = (DATA_W+1)'(START);
    localparam logic [DATA_W:0]  EndX   = (DATA_W+1)'(END);
    localparam logic [DATA_W:0]  StepX  = (DATA_W+1)'(STEP);
    localparam logic [DATA_W-1:0] StartD = DATA_W'(START);
    localparam logic [PassW-1:0] LoopsP = PassW'(LOOPS);

    typedef enum logic [1:0] {StIdle, StWait, StPresent, StDone} state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                dir_q, dir_d;  // 1 = descending
    logic [PassW-1:0]    pass_q, pass_d;

    logic [PERIOD_W-1:0] period_eff;
    logic [DATA_W:0]     up_sum;
    logic [DATA_W:0]     dn_diff;
    logic                up_ok;
    logic                dn_ok;
    logic                is_last;
    logic [DATA_W-1:0]   nxt_data;
    logic                nxt_dir;
    logic [PassW-1:0]    pass_inc;

    assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

    // Sequence math at DATA_W+1 bits so nothing wraps through 2^DATA_W.
    assign up_sum  = {1'b0, data_q} + StepX;
    assign dn_diff = {1'b0, data_q} - StepX;
    assign up_ok   = (up_sum <= EndX);
    assign dn_ok   = ({1'b0, data_q} >= StepX) && (dn_diff >= StartX);
    assign is_last = (MODE == 0 || !dir_q) ? !up_ok : !dn_ok;
    assign pass_inc = pass_q + PassW'(1);

    always_comb begin
        nxt_data = StartD;
        nxt_dir  = dir_q;
        if (MODE == 0) begin
            nxt_data = up_ok ? up_sum[DATA_W-1:0] : StartD;
        end else if (!dir_q) begin
            if (up_ok) begin
                nxt_data = up_sum[DATA_W-1:0];
            end else begin
                nxt_dir  = 1'b1;
                nxt_data = dn_ok ? dn_diff[DATA_W-1:0] : StartD;
            end
        end else begin
            if (dn_ok) begin
                nxt_data = dn_diff[DATA_W-1:0];
            end else begin
                nxt_dir  = 1'b0;
                nxt_data = up_ok ? up_sum[DATA_W-1:0] : StartD;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        period_d = period_q;
        data_d   = data_q;
        dir_d    = dir_q;
        pass_d   = pass_q;
        if (restart) begin
            state_d = StIdle;
            timer_d = '0;
            pass_d  = '0;
            data_d  = StartD;
            dir_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        period_d = period_eff;
                        timer_d  = '0;
                        state_d  = StWait;
                    end
                end
                StWait: begin
                    if (enable) begin
                        if (timer_q == period_q - PERIOD_W'(1)) begin
                            timer_d = '0;
                            state_d = StPresent;
                        end else begin
                            timer_d = timer_q + PERIOD_W'(1);
                        end
                    end
                end
                StPresent: begin
                    if (out_ready) begin
                        data_d   = nxt_data;
                        dir_d    = nxt_dir;
                        period_d = period_eff;
                        if (is_last) begin
                            pass_d = pass_inc;
                        end
                        if (LOOPS != 0 && is_last && pass_inc == LoopsP) begin
                            state_d = StDone;
                        end else if (period_eff == PERIOD_W'(1)) begin
                            state_d = StPresent;
                        end else begin
                            // The handshake cycle counts as the first of the period.
                            timer_d = PERIOD_W'(1);
                            state_d = StWait;
                        end
                    end
                end
                StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            period_q <= PERIOD_W'(1);
            data_q   <= StartD;
            dir_q    <= 1'b0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
            pass_q   <= pass_d;
        end
    end

    assign out_valid = (state_q == StPresent);
    assign out_data  = data_q;
    assign out_last  = out_valid && is_last;
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_beat_pattern_gen.sv
// Directed bench for beat_pattern_gen: five instances (wrap, bounce, loop-limited, overflow-edge,
// degenerate bounce) share one stimulus stream; expectations are hand-computed tables.
module tb_beat_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        restart;
    logic [15:0] period;
    logic        out_ready;

    logic       w_valid, w_last, w_done;
    logic [7:0] w_data;
    logic       b_valid, b_last, b_done;
    logic [7:0] b_data;
    logic       l_valid, l_last, l_done;
    logic [7:0] l_data;
    logic       o_valid, o_last, o_done;
    logic [7:0] o_data;
    logic       d_valid, d_last, d_done;
    logic [7:0] d_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    beat_pattern_gen u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .period(period),
        .out_ready(out_ready), .out_valid(w_valid), .out_data(w_data), .out_last(w_last),
        .done(w_done)
    );

    beat_pattern_gen #(.MODE(1)) u_bounce (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .period(period),
        .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data), .out_last(b_last),
        .done(b_done)
    );

    beat_pattern_gen #(.START(0), .END(10), .STEP(3), .LOOPS(2)) u_loop (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .period(period),
        .out_ready(out_ready), .out_valid(l_valid), .out_data(l_data), .out_last(l_last),
        .done(l_done)
    );

    beat_pattern_gen #(.START(250), .END(255), .STEP(4)) u_ovf (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .period(period),
        .out_ready(out_ready), .out_valid(o_valid), .out_data(o_data), .out_last(o_last),
        .done(o_done)
    );

    beat_pattern_gen #(.START(5), .END(5), .STEP(2), .MODE(1)) u_deg (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .period(period),
        .out_ready(out_ready), .out_valid(d_valid), .out_data(d_data), .out_last(d_last),
        .done(d_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int w_exp_data [10] = '{200, 204, 208, 212, 216, 200, 204, 208, 212, 216};
    int w_exp_last [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int b_exp_data [10] = '{200, 204, 208, 212, 216, 212, 208, 204, 200, 204};
    int b_exp_last [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    int l_exp_data [8]  = '{0, 3, 6, 9, 0, 3, 6, 9};
    int l_exp_last [8]  = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        restart   = 1'b0;
        period    = 16'd1;
        out_ready = 1'b1;

        tick();
        chk("rst_valid", w_valid, 0);
        chk("rst_data", w_data, 200);
        chk("rst_last", w_last, 0);
        chk("rst_done", w_done, 0);
        chk("rst_deg_last", d_last, 0);
        chk("rst_ovf_data", o_data, 250);

        reset = 1'b0;
        tick();
        chk("idle_no_enable", w_valid, 0);

        enable = 1'b1;
        tick();
        chk("wait_valid", w_valid, 0);

        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("w_valid[%0d]", i), w_valid, 1);
            chk($sformatf("w_data[%0d]", i), w_data, w_exp_data[i]);
            chk($sformatf("w_last[%0d]", i), w_last, w_exp_last[i]);
            chk($sformatf("w_done[%0d]", i), w_done, 0);
            chk($sformatf("b_data[%0d]", i), b_data, b_exp_data[i]);
            chk($sformatf("b_last[%0d]", i), b_last, b_exp_last[i]);
            chk($sformatf("o_data[%0d]", i), o_data, (i % 2 == 0) ? 250 : 254);
            chk($sformatf("o_last[%0d]", i), o_last, (i % 2 == 0) ? 0 : 1);
            chk($sformatf("d_data[%0d]", i), d_data, 5);
            chk($sformatf("d_last[%0d]", i), d_last, 1);
            if (i < 8) begin
                chk($sformatf("l_valid[%0d]", i), l_valid, 1);
                chk($sformatf("l_data[%0d]", i), l_data, l_exp_data[i]);
                chk($sformatf("l_last[%0d]", i), l_last, l_exp_last[i]);
                chk($sformatf("l_done[%0d]", i), l_done, 0);
            end else begin
                chk($sformatf("l_valid[%0d]", i), l_valid, 0);
                chk($sformatf("l_done[%0d]", i), l_done, 1);
            end
        end

        tick();
        tick();
        chk("done_hold_valid", l_valid, 0);
        chk("done_hold_done", l_done, 1);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_done", l_done, 0);
        chk("restart_valid", l_valid, 0);
        chk("restart_data", l_data, 0);
        chk("restart_w_data", w_data, 200);
        tick();
        chk("restart_wait", l_valid, 0);
        tick();
        chk("resume_valid", l_valid, 1);
        chk("resume_data", l_data, 0);
        chk("resume_w_data", w_data, 200);

        // Backpressure on 208
        tick();
        chk("bp_204", w_data, 204);
        tick();
        chk("bp_208", w_data, 208);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_valid[%0d]", i), w_valid, 1);
            chk($sformatf("stall_data[%0d]", i), w_data, 208);
        end
        out_ready = 1'b1;
        tick();
        chk("after_stall_data", w_data, 212);
        chk("after_stall_valid", w_valid, 1);

        // Period 4: handshake then exactly 4 cycles to the next valid
        period = 16'd4;
        tick();
        chk("p4_gap0", w_valid, 0);
        tick();
        chk("p4_gap1", w_valid, 0);
        tick();
        chk("p4_gap2", w_valid, 0);
        tick();
        chk("p4_beat_valid", w_valid, 1);
        chk("p4_beat_data", w_data, 216);
        chk("p4_beat_last", w_last, 1);
        tick();
        chk("p4_gap3", w_valid, 0);
        tick();
        tick();
        chk("p4_gap4", w_valid, 0);
        tick();
        chk("p4_beat2_valid", w_valid, 1);
        chk("p4_beat2_data", w_data, 200);

        // Enable low for two cycles mid-WAIT delays the beat by two
        tick();
        chk("en_gap0", w_valid, 0);
        enable = 1'b0;
        tick();
        tick();
        chk("en_frozen", w_valid, 0);
        enable = 1'b1;
        tick();
        tick();
        chk("en_late_gap", w_valid, 0);
        tick();
        chk("en_beat_valid", w_valid, 1);
        chk("en_beat_data", w_data, 204);

        // Period 0 behaves as period 1
        period = 16'd0;
        tick();
        chk("p0_valid0", w_valid, 1);
        chk("p0_data0", w_data, 208);
        tick();
        chk("p0_valid1", w_valid, 1);
        chk("p0_data1", w_data, 212);

        // Asynchronous reset while valid is pending
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", w_valid, 0);
        chk("async_rst_data", w_data, 200);
        chk("async_rst_last", w_last, 0);
        chk("async_rst_ovf", o_data, 250);
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beat_pattern_gen.md
Name: beat_pattern_gen

Overview:
- Parametrised beatmap note-value generator: emits a repeating arithmetic sequence from START to END in steps of STEP.
- Supports wrap or ping-pong (bounce) traversal, a runtime beat period, and an optional finite loop count.
- Output uses a valid/ready handshake so downstream note FIFOs or renderers can apply backpressure.
- Multiple instances with different parameters generate the lanes of a beatmap.

Parameters:
- DATA_W, 8, width of out_data.
- START, 200, first value; legal range START <= END < 2^DATA_W.
- END, 216, upper bound; largest emitted value is START + k*STEP <= END.
- STEP, 4, increment; must be >= 1.
- MODE, 0, traversal mode: 0 = wrap, 1 = bounce.
- LOOPS, 0, number of passes before stopping; 0 = run forever.
- PERIOD_W, 16, width of the period input.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- enable, in, 1, run gate; beat timer advances only while high.
- restart, in, 1, synchronous return to initial sequence state.
- period, in, PERIOD_W, cycles from handshake to next out_valid; 0 is treated as 1.
- out_ready, in, 1, downstream accept.
- out_valid, out, 1, out_data valid.
- out_data, out, DATA_W, current note value.
- out_last, out, 1, out_data is the final element of a pass.
- done, out, 1, LOOPS passes completed.

Behaviour:
- Reset values: out_valid=0, out_data=START, out_last=0, done=0, direction=up, pass count=0, timer=0, state=IDLE.
- State IDLE:
  - Waits for enable=1.
  - On that edge, samples period_eff = max(period, 1) and enters WAIT.
- State WAIT:
  - Timer increments on each enabled cycle; it freezes while enable=0.
  - When the timer reaches period_eff-1, the next state is PRESENT with out_valid=1.
  - Net timing: the first out_valid occurs period_eff enabled cycles after IDLE exits.
- State PRESENT:
  - out_valid=1; out_data and out_last are held stable until out_ready=1. Valid is never retracted except by reset or restart.
  - enable=0 does not drop a pending valid.
- Handshake (out_valid & out_ready):
  - Advance to the next value.
  - If period_eff==1, stay in PRESENT with the next value asserted on the next cycle (1 beat/cycle throughput).
  - Otherwise, go to WAIT with period resampled; the next out_valid asserts exactly period_eff cycles after the handshake, with enable held high.
  - period changes during WAIT are ignored until the next sample.
- Arithmetic:
  - Next value is computed at DATA_W+1 bits, so the sequence never wraps through 2^DATA_W.
  - Example: START=250, END=255, STEP=4 gives 250, 254, 250, ...
- Wrap mode:
  - next = cur+STEP if cur+STEP <= END, else START.
  - out_last=1 on the value whose successor is START.
- Bounce mode, ascending:
  - Same as wrap until cur+STEP > END; then flip direction to down and emit cur-STEP.
  - The top value has out_last=1.
- Bounce mode, descending:
  - next = cur-STEP while cur-STEP >= START; otherwise flip to up and emit cur+STEP.
  - START reached while descending has out_last=1.
  - The initial START after reset/restart has out_last=0.
- Degenerate START==END:
  - Constant output, out_last=1 on every beat, in both modes.
  - In bounce mode the direction flips every beat, with no effect on the value.
- Pass counting and DONE:
  - Pass count increments on each handshake with out_last=1.
  - If LOOPS>0 and the count reaches LOOPS, go to DONE: out_valid=0, done=1.
  - DONE holds until restart or reset; enable is ignored in DONE.
- Restart:
  - Priority over all events in that cycle, including a simultaneous handshake.
  - Clears out_valid, done, timer and pass count; out_data=START, direction=up; state=IDLE.
- Reset mid-operation: asynchronously forces all reset values immediately, including dropping a pending out_valid.

Test Plan:
- Defaults, period=1, enable=1, out_ready=1 -> out_data sequence 200, 204, 208, 212, 216, 200, 204; out_valid continuous from the first beat; out_last high only on 216; done=0 throughout.
- Defaults, period=1, out_ready low for 3 cycles while 208 is presented -> out_valid stays 1 and out_data=208 stable for all 3 cycles; 212 follows the cycle after ready rises; no value is skipped.
- MODE=1, period=1, ready=1 -> 200, 204, 208, 212, 216, 212, 208, 204, 200, 204; out_last on 216 and on the descending 200 only.
- START=0, END=10, STEP=3, LOOPS=2, period=1 -> 0, 3, 6, 9, 0, 3, 6, 9, then out_valid=0 and done=1 held; pulse restart -> done=0 and the sequence resumes at 0.
- period=4, ready=1 -> out_valid pulses one cycle every 4 cycles; period=0 -> same behaviour as period=1; enable dropped for 2 cycles mid-WAIT -> that beat is delayed by exactly 2 cycles.
- Overflow and reset: START=250, END=255, STEP=4 -> 250, 254, 250. Separately, assert reset while out_valid=1 -> out_valid=0 and out_data=START in the same cycle, with no clock edge needed.
